axi_wr_arbiter: RTL

//  Round-robin arbiter sharing one AXI4 master write port between N_REQ pixel writers
//  (e.g. SD-card BMP loader, test-pattern generator) that target the frame buffer.

---
 rtl/axi_wr_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter that shares one AXI4 write master between N_REQ single-beat writers.
// Optional per-requester completion counters are enabled with `define AXI_WR_ARB_CNT_EN.
//
// state  | meaning
// S_IDLE | waiting for a request; grants the first valid index at or after r_ptr
// S_XFER | AW and W channels in flight, each dropped independently after its handshake
// S_RESP | bready high, waiting for the B response of the current owner
module axi_wr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_aresetn,
    input  logic [31:0]          base_addr_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [32*N_REQ-1:0]  req_addr_i,
    input  logic [32*N_REQ-1:0]  req_data_i,
    output logic [N_REQ-1:0]     req_done_o,
    output logic [N_REQ-1:0]     req_error_o,
    output logic [31:0]          m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awlock,
    output logic [3:0]           m_axi_awcache,
    output logic [2:0]           m_axi_awprot,
    output logic [3:0]           m_axi_awqos,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready
`ifdef AXI_WR_ARB_CNT_EN
    ,
    input  logic                 cnt_clr_i,
    output logic [32*N_REQ-1:0]  wr_cnt_o
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [31:0]       r_awaddr;
    logic [31:0]       r_wdata;
    logic              r_awvalid;
    logic              r_wvalid;

    logic              w_gnt_any;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [PTR_W-1:0]  w_scan;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic [N_REQ-1:0]  w_owner_oh;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_data;
    logic              w_aw_done;
    logic              w_w_done;
    logic              w_b_hs;

    // Scan from the highest offset down so the closest valid index to r_ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = r_ptr;
        w_scan    = r_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_scan = PTR_W'((int'(r_ptr) + i) % N_REQ);
            if (req_valid_i[w_scan]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    always_comb begin
        w_gnt_oh              = '0;
        w_gnt_oh[w_gnt_idx]   = 1'b1;
        w_owner_oh            = '0;
        w_owner_oh[r_owner]   = 1'b1;
    end

    assign w_ptr_nxt  = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_addr = req_addr_i[int'(w_gnt_idx)*32 +: 32];
    assign w_sel_data = req_data_i[int'(w_gnt_idx)*32 +: 32];
    assign w_aw_done  = !r_awvalid || m_axi_awready;
    assign w_w_done   = !r_wvalid  || m_axi_wready;
    assign w_b_hs     = (r_state == S_RESP) && m_axi_bvalid;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_owner   <= w_gnt_idx;
                        r_ptr     <= w_ptr_nxt;
                        r_awaddr  <= base_addr_i + w_sel_addr;
                        r_wdata   <= w_sel_data;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done)      r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (m_axi_bvalid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (r_state == S_IDLE && w_gnt_any) ? w_gnt_oh : '0;
    assign req_done_o    = w_b_hs ? w_owner_oh : '0;
    assign req_error_o   = (w_b_hs && (m_axi_bresp != 2'b00)) ? w_owner_oh : '0;

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = 8'h00;
    assign m_axi_awsize  = 3'h2;
    assign m_axi_awburst = 2'h1;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'h0;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = r_wvalid;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == S_RESP);

`ifdef AXI_WR_ARB_CNT_EN
    logic [31:0] r_cnt [N_REQ];

    // Clear has priority over a same-cycle completion.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            for (int k = 0; k < N_REQ; k++) r_cnt[k] <= '0;
        end else if (cnt_clr_i) begin
            for (int k = 0; k < N_REQ; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_done_o[k]) r_cnt[k] <= r_cnt[k] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign wr_cnt_o[g*32 +: 32] = r_cnt[g];
    end
`endif

endmodule
